// File: rtl/morse_char_sequencer.sv
// morse_char_sequencer
//   Keys one ASCII character (A-Z, a-z, 0-9) as ITU Morse on key_out.
//   A dot is 1 unit of mark and a dash is 3 units. Every element is followed
//   by a 1-unit space. The last element's space is extended by 2 more units,
//   so characters are separated by 3 units in total.
//   One unit is UNIT_CYCLES clocks.
//
// Ports
//   CLK      system clock, rising edge
//   RST      asynchronous active-high reset
//   char_in  7-bit ASCII code, captured only when start is accepted
//   start    send request, honoured only while idle
//   busy     high while a character (including trailing gap) is in progress
//   key_out  keying line, 1 = mark/tone
//   done     one-cycle pulse as busy falls at the end of a character
//   invalid  one-cycle pulse when start is seen with an unsupported code
module morse_char_sequencer #(
  parameter int UNIT_CYCLES = 12500000,
  parameter int CNT_W       = $clog2(UNIT_CYCLES*3)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] char_in,
  input  logic       start,
  output logic       busy,
  output logic       key_out,
  output logic       done,
  output logic       invalid
);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, CHAR_GAP} state_t;

  // Terminal counts: the counter starts at 0 on state entry, so a stay of
  // N cycles ends when the counter reads N-1.
  localparam logic [CNT_W-1:0] DOT_LAST  = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_LAST = CNT_W'(3*UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP2_LAST = CNT_W'(2*UNIT_CYCLES - 1);

  // ROM word: {valid, length[2:0], pattern[4:0]}.
  // The pattern is left-justified so bit 4 is always the element being sent
  // (1 = dash, 0 = dot), and the pattern shifts left after each element.
  function automatic logic [8:0] rom_lookup(input logic [6:0] code);
    logic [6:0] up;
    logic [8:0] w;
    up = code;
    if (code >= 7'h61 && code <= 7'h7A) begin
      up = code - 7'h20;
    end
    case (up)
      7'h41: w = {1'b1, 3'd2, 5'b01000}; // A .-
      7'h42: w = {1'b1, 3'd4, 5'b10000}; // B -...
      7'h43: w = {1'b1, 3'd4, 5'b10100}; // C -.-.
      7'h44: w = {1'b1, 3'd3, 5'b10000}; // D -..
      7'h45: w = {1'b1, 3'd1, 5'b00000}; // E .
      7'h46: w = {1'b1, 3'd4, 5'b00100}; // F ..-.
      7'h47: w = {1'b1, 3'd3, 5'b11000}; // G --.
      7'h48: w = {1'b1, 3'd4, 5'b00000}; // H ....
      7'h49: w = {1'b1, 3'd2, 5'b00000}; // I ..
      7'h4A: w = {1'b1, 3'd4, 5'b01110}; // J .---
      7'h4B: w = {1'b1, 3'd3, 5'b10100}; // K -.-
      7'h4C: w = {1'b1, 3'd4, 5'b01000}; // L .-..
      7'h4D: w = {1'b1, 3'd2, 5'b11000}; // M --
      7'h4E: w = {1'b1, 3'd2, 5'b10000}; // N -.
      7'h4F: w = {1'b1, 3'd3, 5'b11100}; // O ---
      7'h50: w = {1'b1, 3'd4, 5'b01100}; // P .--.
      7'h51: w = {1'b1, 3'd4, 5'b11010}; // Q --.-
      7'h52: w = {1'b1, 3'd3, 5'b01000}; // R .-.
      7'h53: w = {1'b1, 3'd3, 5'b00000}; // S ...
      7'h54: w = {1'b1, 3'd1, 5'b10000}; // T -
      7'h55: w = {1'b1, 3'd3, 5'b00100}; // U ..-
      7'h56: w = {1'b1, 3'd4, 5'b00010}; // V ...-
      7'h57: w = {1'b1, 3'd3, 5'b01100}; // W .--
      7'h58: w = {1'b1, 3'd4, 5'b10010}; // X -..-
      7'h59: w = {1'b1, 3'd4, 5'b10110}; // Y -.--
      7'h5A: w = {1'b1, 3'd4, 5'b11000}; // Z --..
      7'h30: w = {1'b1, 3'd5, 5'b11111}; // 0 -----
      7'h31: w = {1'b1, 3'd5, 5'b01111}; // 1 .----
      7'h32: w = {1'b1, 3'd5, 5'b00111}; // 2 ..---
      7'h33: w = {1'b1, 3'd5, 5'b00011}; // 3 ...--
      7'h34: w = {1'b1, 3'd5, 5'b00001}; // 4 ....-
      7'h35: w = {1'b1, 3'd5, 5'b00000}; // 5 .....
      7'h36: w = {1'b1, 3'd5, 5'b10000}; // 6 -....
      7'h37: w = {1'b1, 3'd5, 5'b11000}; // 7 --...
      7'h38: w = {1'b1, 3'd5, 5'b11100}; // 8 ---..
      7'h39: w = {1'b1, 3'd5, 5'b11110}; // 9 ----.
      default: w = 9'd0;
    endcase
    return w;
  endfunction

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [4:0]       pat_reg, pat_next;
  logic [2:0]       rem_reg, rem_next;   // elements left, including current
  logic             busy_next, key_next, done_next, invalid_next;
  logic [8:0]       rom_word;

  assign rom_word = rom_lookup(char_in);

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + CNT_W'(1);
    pat_next     = pat_reg;
    rem_next     = rem_reg;
    done_next    = 1'b0;
    invalid_next = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (start) begin
          if (rom_word[8]) begin
            state_next = MARK;
            rem_next   = rom_word[7:5];
            pat_next   = rom_word[4:0];
          end else begin
            invalid_next = 1'b1;
          end
        end
      end
      MARK: begin
        if (cnt_reg == (pat_reg[4] ? DASH_LAST : DOT_LAST)) begin
          state_next = SPACE;
          cnt_next   = '0;
        end
      end
      SPACE: begin
        if (cnt_reg == DOT_LAST) begin
          cnt_next = '0;
          if (rem_reg > 3'd1) begin
            state_next = MARK;
            rem_next   = rem_reg - 3'd1;
            pat_next   = {pat_reg[3:0], 1'b0};
          end else begin
            state_next = CHAR_GAP;
          end
        end
      end
      CHAR_GAP: begin
        if (cnt_reg == GAP2_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    // Outputs are registered copies of the next state, so they change on the
    // same edge as the state itself.
    busy_next = (state_next != IDLE);
    key_next  = (state_next == MARK);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      pat_reg   <= '0;
      rem_reg   <= '0;
      busy      <= 1'b0;
      key_out   <= 1'b0;
      done      <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pat_reg   <= pat_next;
      rem_reg   <= rem_next;
      busy      <= busy_next;
      key_out   <= key_next;
      done      <= done_next;
      invalid   <= invalid_next;
    end
  end

endmodule

// File: tb/tb_morse_char_sequencer.sv
// Testbench for morse_char_sequencer with UNIT_CYCLES=4.
// Stimulus pushes expected characters (busy length, idle gap before it,
// key_out run lengths) into a scoreboard. A negedge monitor rebuilds the
// observed waveform and checks it when busy falls, or when invalid pulses.
module tb_morse_char_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [6:0] char_in = 7'h00;
  logic       start = 1'b0;
  logic       busy, key_out, done, invalid;

  morse_char_sequencer #(.UNIT_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST), .char_in(char_in), .start(start),
    .busy(busy), .key_out(key_out), .done(done), .invalid(invalid)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic inv;
    int   busy_len;
    int   gap;      // idle cycles before busy rises, -1 = don't care
    int   nruns;
  } exp_t;

  exp_t exp_q[$];
  int   exp_runs[$];
  int   rv [10];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic exp_push(input logic inv, input int b, input int g, input int n);
    exp_t e;
    e.inv = inv; e.busy_len = b; e.gap = g; e.nruns = n;
    exp_q.push_back(e);
    for (int i = 0; i < n; i++) exp_runs.push_back(rv[i]);
  endtask

  // ---------------- monitor ----------------
  int   obs_runs[$];
  logic in_char = 1'b0;
  logic cur_lvl, first_lvl;
  int   cur_len, busy_obs, gap_obs;
  int   idle_cnt = 1000;

  task automatic check_char();
    exp_t e;
    int   r;
    chk("done_at_busy_fall", int'(done), 1);
    if (exp_q.size() == 0) begin
      chk("unexpected_char", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("char_kind", 0, int'(e.inv));
      chk("busy_cycles", busy_obs, e.busy_len);
      if (e.gap >= 0) chk("idle_gap", gap_obs, e.gap);
      chk("first_level", int'(first_lvl), 1);
      chk("run_count", obs_runs.size(), e.nruns);
      for (int i = 0; i < e.nruns; i++) begin
        r = exp_runs.pop_front();
        if (i < obs_runs.size()) chk($sformatf("run%0d", i), obs_runs[i], r);
      end
      $display("char done: busy=%0d runs=%0d", busy_obs, obs_runs.size());
    end
  endtask

  task automatic check_invalid();
    exp_t e;
    chk("invalid_busy", int'(busy), 0);
    if (exp_q.size() == 0) begin
      chk("unexpected_invalid", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("invalid_kind", 1, int'(e.inv));
      $display("invalid pulse seen");
    end
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      in_char  = 1'b0;
      obs_runs.delete();
      idle_cnt = 1000;
    end else begin
      if (done && invalid) chk("done_and_invalid", 1, 0);
      if (!busy && key_out) chk("key_without_busy", 1, 0);
      if (busy) begin
        if (!in_char) begin
          in_char   = 1'b1;
          gap_obs   = idle_cnt;
          busy_obs  = 0;
          obs_runs.delete();
          first_lvl = key_out;
          cur_lvl   = key_out;
          cur_len   = 0;
        end
        busy_obs++;
        if (key_out == cur_lvl) begin
          cur_len++;
        end else begin
          obs_runs.push_back(cur_len);
          cur_lvl = key_out;
          cur_len = 1;
        end
        if (done) chk("done_while_busy", 1, 0);
      end else if (in_char) begin
        in_char = 1'b0;
        obs_runs.push_back(cur_len);
        idle_cnt = 0;
        check_char();
      end else if (done) begin
        chk("spurious_done", 1, 0);
      end
      if (!busy) idle_cnt++;
      if (invalid) check_invalid();
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [6:0] c);
    @(posedge CLK); #2;
    char_in = c;
    start   = 1'b1;
    @(posedge CLK); #2;
    start   = 1'b0;
    char_in = 7'h21;   // scribble: must not affect the character in flight
  endtask

  task automatic wait_idle();
    int ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin ok = 1; break; end
      @(posedge CLK); #2;
    end
    chk("wait_idle_timeout", ok, 1);
    repeat (3) @(posedge CLK);
  endtask

  task automatic wait_done();
    int ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge CLK); #2;
      if (done) begin ok = 1; break; end
    end
    chk("wait_done_timeout", ok, 1);
  endtask

  logic [6:0] bad_codes [8];

  initial begin
    bad_codes = '{7'h21, 7'h40, 7'h5B, 7'h2F, 7'h3A, 7'h60, 7'h7B, 7'h7F};

    repeat (3) @(posedge CLK);
    #3 RST = 1'b0;
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_key", int'(key_out), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_invalid", int'(invalid), 0);

    // E: one dot
    rv = '{4, 12, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_push(1'b0, 16, -1, 2); send(7'h45); wait_idle();

    // A and a: .-
    rv = '{4, 4, 12, 12, 0, 0, 0, 0, 0, 0};
    exp_push(1'b0, 32, -1, 4); send(7'h41); wait_idle();
    exp_push(1'b0, 32, -1, 4); send(7'h61); wait_idle();

    // 0: -----
    rv = '{12, 4, 12, 4, 12, 4, 12, 4, 12, 12};
    exp_push(1'b0, 88, -1, 10); send(7'h30); wait_idle();

    // unsupported codes around every valid range edge
    foreach (bad_codes[i]) begin
      exp_push(1'b1, 0, -1, 0); send(bad_codes[i]); wait_idle();
    end

    // T with an ignored start mid-dash, then E started on the done cycle
    rv = '{12, 12, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_push(1'b0, 24, -1, 2);
    rv = '{4, 12, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_push(1'b0, 16, 1, 2);
    send(7'h54);
    repeat (3) @(posedge CLK);
    #2 char_in = 7'h45; start = 1'b1;
    @(posedge CLK); #2 start = 1'b0;
    wait_done();
    char_in = 7'h45; start = 1'b1;
    @(posedge CLK); #2 start = 1'b0;
    wait_idle();

    // start held high: back-to-back I I
    rv = '{4, 4, 4, 12, 0, 0, 0, 0, 0, 0};
    exp_push(1'b0, 24, -1, 4);
    exp_push(1'b0, 24, 1, 4);
    @(posedge CLK); #2 char_in = 7'h49; start = 1'b1;
    wait_done();
    @(posedge CLK); #2 start = 1'b0;
    wait_idle();

    // range-edge valid codes
    rv = '{12, 4, 12, 4, 4, 4, 4, 12, 0, 0};
    exp_push(1'b0, 56, -1, 8); send(7'h5A); wait_idle();
    exp_push(1'b0, 56, -1, 8); send(7'h7A); wait_idle();
    rv = '{12, 4, 12, 4, 12, 4, 12, 4, 4, 12};
    exp_push(1'b0, 80, -1, 10); send(7'h39); wait_idle();
    rv = '{12, 4, 12, 4, 4, 4, 12, 12, 0, 0};
    exp_push(1'b0, 64, -1, 8); send(7'h71); wait_idle();

    // asynchronous reset in the middle of a dash
    send(7'h54);
    @(posedge CLK); #2;
    chk("mid_dash_key", int'(key_out), 1);
    #1 RST = 1'b1;
    #1;
    chk("async_rst_key", int'(key_out), 0);
    chk("async_rst_busy", int'(busy), 0);
    @(posedge CLK); #3 RST = 1'b0;
    #1;
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_key", int'(key_out), 0);
    rv = '{4, 12, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_push(1'b0, 16, -1, 2); send(7'h45); wait_idle();

    repeat (5) @(posedge CLK);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
